fetch_ctrl: RTL and testbench
=============================

FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 SHALL have parameter PC_W, default 11, meaning program counter width in bits.
REQ-002 SHALL have parameter LUT_AW, default 6, meaning branch-target table index width; table depth is 2**LUT_AW.
REQ-003 SHALL have parameter RAS_DEPTH, default 4, meaning return-address stack entries (at least 1).
REQ-004 SHALL have parameter LAST_PC, default 2**PC_W-1, meaning the address whose fetch ends the program.
REQ-005 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-006 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-007 SHALL have port req, input, 1, start/restart request.
REQ-008 SHALL have port stall, input, 1, freezes PC and stack when high.
REQ-009 SHALL have port done, input, 1, halt instruction decoded at current pc_out.
REQ-010 SHALL have port br_taken, input, 1, branch taken.
REQ-011 SHALL have port jmp, input, 1, 1 = absolute target, 0 = PC-relative signed offset.
REQ-012 SHALL have port call, input, 1, call to absolute target.
REQ-013 SHALL have port ret, input, 1, return.
REQ-014 SHALL have port lut_idx, input, LUT_AW, target table read index.
REQ-015 SHALL have port lut_we / lut_waddr / lut_wdata, input, 1 / LUT_AW / PC_W, target table write port.
REQ-016 SHALL have port pc_out, output, PC_W, current fetch address.
REQ-017 SHALL have port halt, output, 1, program finished.
REQ-018 SHALL have port ras_err, output, 1, sticky stack overflow/underflow flag.

Function
REQ-019 SHALL implement states IDLE, RUN, HALT.
REQ-020 SHALL, in IDLE, hold pc_out = 0 and halt = 0, and move to RUN on the cycle after req = 1; the first RUN cycle presents pc_out = 0.
REQ-021 SHALL, in RUN with stall = 0, compute next PC with priority ret > call > br_taken > sequential; lower-priority inputs are ignored in the same cycle.
REQ-022 SHALL use pc_out + 1 for sequential flow, wrapping modulo 2**PC_W.
REQ-023 SHALL, on br_taken with jmp = 1, load pc_out = T, where T is the table entry at lut_idx.
REQ-024 SHALL, on br_taken with jmp = 0, load pc_out = pc_out + T, with T treated as signed and the sum taken modulo 2**PC_W.
REQ-025 SHALL, on call, push pc_out + 1 and load pc_out = T as an absolute target.
REQ-026 SHALL, on call with the stack full, drop the push, still take the jump, and set ras_err.
REQ-027 SHALL, on ret with the stack non-empty, pop and load the popped value.
REQ-028 SHALL, on ret with the stack empty, advance pc_out + 1 and set ras_err.
REQ-029 SHALL, in RUN with stall = 1, hold pc_out, stack and state unchanged; done, req and branch inputs are ignored.
REQ-030 SHALL, in RUN with stall = 0, go to HALT on the next edge when done = 1 or pc_out = LAST_PC; done has priority over every PC update.
REQ-031 SHALL, in HALT, hold pc_out and assert halt = 1.
REQ-032 SHALL, in HALT with req = 1, go to RUN with pc_out = 0, halt = 0, stack emptied and ras_err cleared.
REQ-033 SHALL, in RUN, ignore req.
REQ-034 SHALL accept table writes in any state.
REQ-035 SHALL return the old table value on a same-cycle read and write of the same index.
REQ-036 SHALL make the table read combinational from lut_idx.

Reset
REQ-037 SHALL, on reset, enter IDLE with pc_out = 0, halt = 0, ras_err = 0 and the stack empty, regardless of state or stall.
REQ-038 SHALL retain table contents through reset.
REQ-039 SHALL let reset take priority over every other input.

Verification
REQ-040 SHALL cover start: reset, then req pulse -> pc_out 0,1,2,3 on successive cycles, halt = 0.
REQ-041 SHALL cover branches: table[5] = 0x7FE (-2 signed), pc = 10, br_taken, jmp = 0, lut_idx = 5 -> pc = 8; table[3] = 100, jmp = 1 -> pc = 100.
REQ-042 SHALL cover the stack with RAS_DEPTH = 4: 5 calls to target 200 from pc = 20 -> 5th call jumps, ras_err = 1; 4 rets return 201,201,201,21; a 5th ret -> pc + 1.
REQ-043 SHALL cover done: done at pc = 7 with stall = 1 -> no halt; stall dropped -> HALT next cycle, halt = 1, pc held at 7; req -> pc = 0, halt = 0.
REQ-044 SHALL cover priority: ret, call and br_taken asserted together -> only the pop occurs.
REQ-045 SHALL cover wrap and reset: wrap at LAST_PC = 2047 -> halt, not wrap; LAST_PC = 4095 with PC_W = 11 -> 2047 wraps to 0; reset mid-RUN -> pc = 0, IDLE.

Source files
------------

// File: rtl/fetch_ctrl.sv
// fetch_ctrl -- instruction fetch sequencer with a branch-target table and a
// return-address stack.
//
// Ports:
//   clk        single clock; all state changes on its rising edge
//   reset      synchronous active-high reset (IDLE, pc 0, stack empty)
//   req        start / restart request (honoured in IDLE and HALT)
//   stall      freezes pc, stack and state while in RUN
//   done       halt instruction decoded at the current pc_out
//   br_taken   branch taken; jmp selects absolute (1) or signed relative (0)
//   call       call to absolute table target, pushes pc_out + 1
//   ret        return to the most recently pushed address
//   lut_idx    combinational read index into the branch-target table
//   lut_we / lut_waddr / lut_wdata   table write port (any state)
//   pc_out     current fetch address
//   halt       program finished
//   ras_err    sticky stack overflow / underflow flag
module fetch_ctrl #(
  parameter int PC_W      = 11,
  parameter int LUT_AW    = 6,
  parameter int RAS_DEPTH = 4,
  parameter int LAST_PC   = 2**PC_W - 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  input  logic              stall,
  input  logic              done,
  input  logic              br_taken,
  input  logic              jmp,
  input  logic              call,
  input  logic              ret,
  input  logic [LUT_AW-1:0] lut_idx,
  input  logic              lut_we,
  input  logic [LUT_AW-1:0] lut_waddr,
  input  logic [PC_W-1:0]   lut_wdata,
  output logic [PC_W-1:0]   pc_out,
  output logic              halt,
  output logic              ras_err
);

  // Occupancy counter must represent 0..RAS_DEPTH inclusive.
  localparam int             CW        = $clog2(RAS_DEPTH + 1);
  localparam logic [CW-1:0]  RAS_FULL  = CW'(RAS_DEPTH);
  localparam logic [31:0]    LAST_PC_U = 32'(LAST_PC);

  typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;

  state_t          state_reg, state_next;
  logic [PC_W-1:0] pc_reg, pc_next;
  logic [CW-1:0]   ras_cnt_reg, ras_cnt_next;
  logic            ras_err_reg, ras_err_next;
  logic            ras_push;

  // Stack storage is sized to the counter range so any counter value is a
  // legal index; only the first RAS_DEPTH entries are ever written.
  logic [PC_W-1:0] ras_mem [2**CW];
  logic [PC_W-1:0] lut_mem [2**LUT_AW];

  logic [PC_W-1:0] lut_q;
  logic [PC_W-1:0] pc_inc;
  logic [PC_W-1:0] ras_top;
  logic            at_last;

  // Combinational read: a same-cycle write lands on the edge, so a read of
  // the same index sees the old contents.
  assign lut_q   = lut_mem[lut_idx];
  assign pc_inc  = pc_reg + PC_W'(1);
  assign ras_top = ras_mem[ras_cnt_reg - CW'(1)];
  // Compared at 32 bits so a LAST_PC beyond the pc range never matches.
  assign at_last = (32'(pc_reg) == LAST_PC_U);

  // Table has no reset: contents survive a reset.
  always_ff @(posedge clk) begin
    if (lut_we) begin
      lut_mem[lut_waddr] <= lut_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (ras_push) begin
      ras_mem[ras_cnt_reg] <= pc_inc;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= IDLE;
      pc_reg      <= '0;
      ras_cnt_reg <= '0;
      ras_err_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      pc_reg      <= pc_next;
      ras_cnt_reg <= ras_cnt_next;
      ras_err_reg <= ras_err_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    pc_next      = pc_reg;
    ras_cnt_next = ras_cnt_reg;
    ras_err_next = ras_err_reg;
    ras_push     = 1'b0;

    unique case (state_reg)
      IDLE: begin
        pc_next = '0;
        if (req) begin
          state_next = RUN;
        end
      end

      RUN: begin
        if (!stall) begin
          // Halting wins over any pc or stack update in the same cycle.
          if (done || at_last) begin
            state_next = HALT;
          end else if (ret) begin
            if (ras_cnt_reg != '0) begin
              pc_next      = ras_top;
              ras_cnt_next = ras_cnt_reg - CW'(1);
            end else begin
              pc_next      = pc_inc;
              ras_err_next = 1'b1;
            end
          end else if (call) begin
            pc_next = lut_q;
            if (ras_cnt_reg != RAS_FULL) begin
              ras_push     = 1'b1;
              ras_cnt_next = ras_cnt_reg + CW'(1);
            end else begin
              ras_err_next = 1'b1;
            end
          end else if (br_taken) begin
            // Modular add equals a signed offset add at this width.
            pc_next = jmp ? lut_q : (pc_reg + lut_q);
          end else begin
            pc_next = pc_inc;
          end
        end
      end

      HALT: begin
        if (req) begin
          state_next   = RUN;
          pc_next      = '0;
          ras_cnt_next = '0;
          ras_err_next = 1'b0;
        end
      end

      default: begin
        state_next = IDLE;
        pc_next    = '0;
      end
    endcase
  end

  assign pc_out  = pc_reg;
  assign halt    = (state_reg == HALT);
  assign ras_err = ras_err_reg;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Testbench for fetch_ctrl: directed vector table, hand-written multi-cycle
// sequences, then randomized stimulus against a queue-based reference model.
module tb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req = 1'b0, stall = 1'b0, done = 1'b0;
  logic        br_taken = 1'b0, jmp = 1'b0, call = 1'b0, ret = 1'b0;
  logic [5:0]  lut_idx = '0;
  logic        lut_we = 1'b0;
  logic [5:0]  lut_waddr = '0;
  logic [10:0] lut_wdata = '0;
  logic [10:0] pc_out, pc2;
  logic        halt, ras_err, halt2, err2;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fetch_ctrl dut (
    .clk(clk), .reset(reset), .req(req), .stall(stall), .done(done),
    .br_taken(br_taken), .jmp(jmp), .call(call), .ret(ret),
    .lut_idx(lut_idx), .lut_we(lut_we), .lut_waddr(lut_waddr),
    .lut_wdata(lut_wdata), .pc_out(pc_out), .halt(halt), .ras_err(ras_err)
  );

  // Same stimulus, but LAST_PC lies outside the 11-bit range: pc must wrap.
  fetch_ctrl #(.LAST_PC(4095)) dut_wide (
    .clk(clk), .reset(reset), .req(req), .stall(stall), .done(done),
    .br_taken(br_taken), .jmp(jmp), .call(call), .ret(ret),
    .lut_idx(lut_idx), .lut_we(lut_we), .lut_waddr(lut_waddr),
    .lut_wdata(lut_wdata), .pc_out(pc2), .halt(halt2), .ras_err(err2)
  );

  // ---------------- reference model (default parameters) ----------------
  // mode: 0 idle, 1 running, 2 halted; stack is a plain queue of addresses.
  int m_mode, m_pc, m_err;
  int m_stk[$];
  int m_lut[64];

  task automatic model_step();
    int t, off;
    t = m_lut[lut_idx];
    if (reset) begin
      m_mode = 0; m_pc = 0; m_err = 0; m_stk.delete();
    end else if (m_mode == 0) begin
      m_pc = 0;
      if (req) m_mode = 1;
    end else if (m_mode == 1) begin
      if (!stall) begin
        if (done || m_pc == 2047) m_mode = 2;
        else if (ret) begin
          if (m_stk.size() > 0) m_pc = m_stk.pop_back();
          else begin m_pc = (m_pc + 1) % 2048; m_err = 1; end
        end else if (call) begin
          if (m_stk.size() < 4) m_stk.push_back((m_pc + 1) % 2048);
          else m_err = 1;
          m_pc = t;
        end else if (br_taken) begin
          if (jmp) m_pc = t;
          else begin
            off  = (t >= 1024) ? t - 2048 : t;
            m_pc = (m_pc + off + 2048) % 2048;
          end
        end else m_pc = (m_pc + 1) % 2048;
      end
    end else if (req) begin
      m_mode = 1; m_pc = 0; m_err = 0; m_stk.delete();
    end
    if (lut_we) m_lut[lut_waddr] = int'(lut_wdata);
  endtask

  // ---------------- helpers ----------------
  task automatic step();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end else begin
      $display("ok   %s: %0d", nm, got);
    end
  endtask

  task automatic chk3(input string nm, input int p, input int h, input int e);
    chk({nm, "_pc"}, int'(pc_out), p);
    chk({nm, "_halt"}, int'(halt), h);
    chk({nm, "_err"}, int'(ras_err), e);
  endtask

  task automatic clr();
    req = 0; stall = 0; done = 0; br_taken = 0; jmp = 0; call = 0; ret = 0;
    lut_idx = '0; lut_we = 0; lut_waddr = '0; lut_wdata = '0;
  endtask

  task automatic wr(input int a, input int d);
    clr();
    lut_we = 1; lut_waddr = 6'(a); lut_wdata = 11'(d);
    step();
    lut_we = 0;
  endtask

  task automatic do_reset();
    clr();
    reset = 1;
    step();
    reset = 0;
    chk3("reset", 0, 0, 0);
  endtask

  // Drive one cycle of control inputs and step.
  task automatic drive(input logic rq, input logic st, input logic dn,
                       input logic br, input logic jp, input logic cl,
                       input logic rt, input int idx);
    clr();
    req = rq; stall = st; done = dn; br_taken = br; jmp = jp;
    call = cl; ret = rt; lut_idx = 6'(idx);
    step();
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic req, stall, done, br, jmp, call, ret;
    int   idx;
    int   pc;
    int   halt;
    int   err;
  } vec_t;

  function automatic vec_t mk(input logic rq, input logic st, input logic dn,
                              input logic br, input logic jp, input logic cl,
                              input logic rt, input int idx, input int p,
                              input int h, input int e);
    vec_t v;
    v.req = rq; v.stall = st; v.done = dn; v.br = br; v.jmp = jp;
    v.call = cl; v.ret = rt; v.idx = idx; v.pc = p; v.halt = h; v.err = e;
    return v;
  endfunction

  vec_t vecs[19];

  initial begin
    //                rq st dn br jp cl rt idx   pc h e
    vecs[0]  = mk(1, 0, 0, 0, 0, 0, 0, 0,    0, 0, 0); // start: first RUN pc 0
    vecs[1]  = mk(0, 0, 0, 0, 0, 0, 0, 0,    1, 0, 0);
    vecs[2]  = mk(0, 0, 0, 0, 0, 0, 0, 0,    2, 0, 0);
    vecs[3]  = mk(0, 0, 0, 0, 0, 0, 0, 0,    3, 0, 0);
    vecs[4]  = mk(0, 0, 0, 1, 1, 0, 0, 2,   10, 0, 0); // absolute to 10
    vecs[5]  = mk(0, 0, 0, 1, 0, 0, 0, 5,    8, 0, 0); // 10 + (-2)
    vecs[6]  = mk(0, 0, 0, 1, 1, 0, 0, 3,  100, 0, 0); // absolute 100
    vecs[7]  = mk(1, 1, 1, 1, 1, 0, 0, 2,  100, 0, 0); // stall holds all
    vecs[8]  = mk(1, 0, 0, 0, 0, 0, 0, 0,  101, 0, 0); // req ignored in RUN
    vecs[9]  = mk(0, 0, 0, 1, 1, 0, 0, 1,    7, 0, 0);
    vecs[10] = mk(0, 1, 1, 0, 0, 0, 0, 0,    7, 0, 0); // done under stall
    vecs[11] = mk(0, 0, 1, 0, 0, 0, 0, 0,    7, 1, 0); // halts, pc held
    vecs[12] = mk(0, 0, 0, 0, 0, 0, 0, 0,    7, 1, 0);
    vecs[13] = mk(1, 0, 0, 0, 0, 0, 0, 0,    0, 0, 0); // restart
    vecs[14] = mk(0, 0, 0, 1, 1, 1, 1, 3,    1, 0, 1); // ret wins, underflow
    vecs[15] = mk(1, 0, 0, 0, 0, 0, 0, 0,    2, 0, 1); // sticky err
    vecs[16] = mk(0, 0, 0, 1, 1, 1, 0, 6,  200, 0, 1); // call wins over br
    vecs[17] = mk(0, 0, 0, 1, 1, 0, 0, 3,  100, 0, 1);
    vecs[18] = mk(0, 0, 0, 0, 0, 0, 1, 0,    3, 0, 1); // pops 3
  end

  // ---------------- main test ----------------
  initial begin
    int rets[4];
    m_mode = 0; m_pc = 0; m_err = 0;
    for (int i = 0; i < 64; i++) m_lut[i] = 0;
    rets[0] = 201; rets[1] = 201; rets[2] = 201; rets[3] = 21;

    // Fill the whole table while reset is held; table writes work anywhere.
    for (int i = 0; i < 64; i++) wr(i, $urandom_range(0, 2047));
    wr(1, 7); wr(2, 10); wr(3, 100); wr(4, 20); wr(5, 'h7FE);
    wr(6, 200); wr(9, 2046); wr(11, 30);

    do_reset();

    for (int i = 0; i < 19; i++) begin
      drive(vecs[i].req, vecs[i].stall, vecs[i].done, vecs[i].br, vecs[i].jmp,
            vecs[i].call, vecs[i].ret, vecs[i].idx);
      chk3($sformatf("vec%0d", i), vecs[i].pc, vecs[i].halt, vecs[i].err);
    end

    // Stack overflow / underflow with depth 4.
    do_reset();
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 1, 1, 0, 0, 4);
    chk3("stk_at20", 20, 0, 0);
    for (int k = 0; k < 5; k++) begin
      drive(0, 0, 0, 0, 0, 1, 0, 6);
      chk3($sformatf("stk_call%0d", k), 200, 0, (k == 4) ? 1 : 0);
    end
    for (int k = 0; k < 4; k++) begin
      drive(0, 0, 0, 0, 0, 0, 1, 0);
      chk3($sformatf("stk_ret%0d", k), rets[k], 0, 1);
    end
    drive(0, 0, 0, 0, 0, 0, 1, 0);
    chk3("stk_ret_empty", 22, 0, 1);
    // Restart from HALT must empty a non-empty stack and clear the flag.
    drive(0, 0, 0, 0, 0, 1, 0, 6);
    drive(0, 0, 1, 0, 0, 0, 0, 0);
    chk3("stk_halt", 200, 1, 1);
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    chk3("stk_restart", 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 1, 0);
    chk3("stk_emptied", 1, 0, 1);

    // Priority: ret + call + br together only pops.
    do_reset();
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 1, 1, 0, 0, 4);
    drive(0, 0, 0, 0, 0, 1, 0, 6);
    chk3("pri_call", 200, 0, 0);
    drive(0, 0, 0, 1, 1, 1, 1, 3);
    chk3("pri_all", 21, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 1, 0);
    chk3("pri_nopush", 22, 0, 1);

    // LAST_PC halts the default instance; the wide instance wraps.
    do_reset();
    chk("wide_reset_pc", int'(pc2), 0);
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 1, 1, 0, 0, 9);
    chk3("wrap_2046", 2046, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    chk3("wrap_2047", 2047, 0, 0);
    chk("wide_2047", int'(pc2), 2047);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    chk3("last_halt", 2047, 1, 0);
    chk("wide_wrap_pc", int'(pc2), 0);
    chk("wide_wrap_halt", int'(halt2), 0);
    chk("wide_wrap_err", int'(err2), 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    chk("wide_after_wrap", int'(pc2), 1);

    // Reset mid-RUN (with stall high) returns to IDLE; table survives.
    do_reset();
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 1, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    chk3("mid_run", 2, 0, 1);
    clr(); stall = 1; reset = 1; step(); reset = 0;
    chk3("mid_reset", 0, 0, 0);
    drive(0, 0, 0, 1, 1, 0, 0, 3);
    chk3("idle_hold", 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 1, 1, 0, 0, 3);
    chk3("lut_retained", 100, 0, 0);

    // Same-cycle read and write of one entry reads the old value.
    clr(); br_taken = 1; jmp = 1; lut_idx = 6'd11;
    lut_we = 1; lut_waddr = 6'd11; lut_wdata = 11'd50;
    step();
    chk3("rw_old", 30, 0, 0);
    drive(0, 0, 0, 1, 1, 0, 0, 11);
    chk3("rw_new", 50, 0, 0);

    // Randomized run against the reference model.
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      reset     = ($urandom_range(0, 199) == 0);
      req       = ($urandom_range(0, 3) == 0);
      stall     = ($urandom_range(0, 4) == 0);
      done      = ($urandom_range(0, 49) == 0);
      br_taken  = ($urandom_range(0, 3) == 0);
      jmp       = 1'($urandom);
      call      = ($urandom_range(0, 6) == 0);
      ret       = ($urandom_range(0, 6) == 0);
      lut_idx   = 6'($urandom);
      lut_we    = ($urandom_range(0, 5) == 0);
      lut_waddr = 6'($urandom);
      lut_wdata = 11'($urandom);
      step();
      chk3($sformatf("rnd%0d", n), m_pc, (m_mode == 2) ? 1 : 0, m_err);
    end
    reset = 0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
